// File: rtl/larpix_rx_pkg.sv
// Shared types for the LArPix PISO lane receiver.
//   DEFAULT_PACKET_W : default data bits per frame
//   rx_state_t       : receiver FSM states
//   rx_entry_t       : FIFO entry at the default packet width
package larpix_rx_pkg;

   localparam int unsigned DEFAULT_PACKET_W = 64;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } rx_state_t;

   typedef struct packed {
      logic                        parity_err;
      logic [DEFAULT_PACKET_W-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/rx_packet_fifo.sv
// First-word-fall-through FIFO of received packet entries.
//   clk, reset : clock, asynchronous active-high reset
//   push, wdata: write request and entry; ignored when full unless a pop happens the same cycle
//   pop        : remove head entry; ignored when empty
//   head       : head entry, all zeros while empty
//   full, empty: occupancy flags
//   count      : occupancy, 0..DEPTH
module rx_packet_fifo
   import larpix_rx_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter type entry_t = rx_entry_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  entry_t                 wdata,
   input  logic                   pop,
   output entry_t                 head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   // Gate the head so the stale storage never shows while empty.
   assign head  = empty ? '0 : mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/piso_packet_receiver.sv
// Receiver for one LArPix PISO UART lane.
//   clk, reset        : clock, asynchronous active-high reset
//   piso_in           : serial line (idles high, asynchronous to clk)
//   packet_data       : head-of-FIFO packet
//   packet_parity_err : head packet failed odd parity
//   packet_valid      : FIFO not empty
//   packet_ready      : consumer accepts head packet
//   fifo_count        : FIFO occupancy
//   framing_err_count : saturating count of bad stop bits
//   overflow_count    : saturating count of packets dropped on a full FIFO
//   clear_counters    : synchronous clear of both counters (beats an increment)
module piso_packet_receiver
   import larpix_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PACKET_W     = DEFAULT_PACKET_W,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        piso_in,
   output logic [PACKET_W-1:0]         packet_data,
   output logic                        packet_parity_err,
   output logic                        packet_valid,
   input  logic                        packet_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]            framing_err_count,
   output logic [CNT_W-1:0]            overflow_count,
   input  logic                        clear_counters
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(PACKET_W);
   localparam logic [TW-1:0] TimerHalf = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TimerFull = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LastIdx   = IW'(PACKET_W - 1);

   typedef struct packed {
      logic                parity_err;
      logic [PACKET_W-1:0] data;
   } pkt_entry_t;

   // Synchronizer resets to idle-high so reset release never looks like a start bit.
   logic [1:0] sync_q;
   logic       rx_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], piso_in};
   end

   assign rx_s = sync_q[1];

   rx_state_t           state_q, state_d;
   logic [TW-1:0]       timer_q;
   logic [IW-1:0]       bit_idx_q;
   logic [PACKET_W-1:0] shift_q;
   logic                expiry;
   logic                load_half, load_full, clr_idx, sample, push, frame_err;

   assign expiry = (timer_q == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (!rx_s) state_d = StStart;
         StStart:    if (expiry) state_d = rx_s ? StIdle : StData;
         StData:     if (expiry && bit_idx_q == LastIdx) state_d = StStop;
         StStop:     if (expiry) state_d = rx_s ? StIdle : StWaitIdle;
         StWaitIdle: if (rx_s) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      load_half = 1'b0;
      load_full = 1'b0;
      clr_idx   = 1'b0;
      sample    = 1'b0;
      push      = 1'b0;
      frame_err = 1'b0;
      unique case (state_q)
         StIdle: load_half = !rx_s;
         StStart: begin
            load_full = expiry && !rx_s;
            clr_idx   = expiry && !rx_s;
         end
         StData: begin
            sample    = expiry;
            load_full = expiry;
         end
         StStop: begin
            push      = expiry && rx_s;
            frame_err = expiry && !rx_s;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         if (load_half)      timer_q <= TimerHalf;
         else if (load_full) timer_q <= TimerFull;
         else                timer_q <= timer_q - TW'(1);

         if (clr_idx)     bit_idx_q <= '0;
         else if (sample) bit_idx_q <= bit_idx_q + IW'(1);

         if (sample) shift_q <= {rx_s, shift_q[PACKET_W-1:1]};
      end
   end

   pkt_entry_t wentry, head;
   logic       fifo_full, fifo_empty, fifo_pop, drop;

   assign wentry.parity_err = ~(^shift_q);
   assign wentry.data       = shift_q;
   assign fifo_pop          = packet_valid && packet_ready;
   assign drop              = push && fifo_full && !fifo_pop;

   rx_packet_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (pkt_entry_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wentry),
      .pop   (fifo_pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign packet_valid      = !fifo_empty;
   assign packet_data       = head.data;
   assign packet_parity_err = head.parity_err;

   logic [CNT_W-1:0] framing_q, overflow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         framing_q  <= '0;
         overflow_q <= '0;
      end else if (clear_counters) begin
         framing_q  <= '0;
         overflow_q <= '0;
      end else begin
         if (frame_err && framing_q != '1) framing_q  <= framing_q + CNT_W'(1);
         if (drop && overflow_q != '1)     overflow_q <= overflow_q + CNT_W'(1);
      end
   end

   assign framing_err_count = framing_q;
   assign overflow_count    = overflow_q;

endmodule

// File: tb/tb_piso_packet_receiver.sv
module tb_piso_packet_receiver;

   localparam int CPB   = 4;
   localparam int PW    = 64;
   localparam int DEPTH = 16;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset, piso_in, packet_ready, clear_counters;
   logic [PW-1:0] packet_data;
   logic          packet_parity_err, packet_valid;
   logic [4:0]    fifo_count;
   logic [CW-1:0] framing_err_count, overflow_count;

   piso_packet_receiver #(
      .CLKS_PER_BIT (CPB),
      .PACKET_W     (PW),
      .FIFO_DEPTH   (DEPTH),
      .CNT_W        (CW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .piso_in           (piso_in),
      .packet_data       (packet_data),
      .packet_parity_err (packet_parity_err),
      .packet_valid      (packet_valid),
      .packet_ready      (packet_ready),
      .fifo_count        (fifo_count),
      .framing_err_count (framing_err_count),
      .overflow_count    (overflow_count),
      .clear_counters    (clear_counters)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   // Reference model: expected FIFO contents {parity_err, data} and counter values.
   logic [PW:0] exp_q[$];
   int          fe_model  = 0;
   int          ovf_model = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW:0] entry_of(input logic [PW-1:0] d);
      int ones = 0;
      for (int i = 0; i < PW; i++) ones += int'(d[i]);
      return {((ones % 2) == 0), d};
   endfunction

   function automatic logic [PW-1:0] rand_data();
      return {$urandom(), $urandom()};
   endfunction

   task automatic drive_bit(input logic b);
      piso_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_count"}, fifo_count, exp_q.size());
      check_eq({tag, "_valid"}, packet_valid, exp_q.size() != 0);
      check_eq({tag, "_fe"}, framing_err_count, fe_model);
      check_eq({tag, "_ovf"}, overflow_count, ovf_model);
   endtask

   // Sends one frame. Returns at the negedge just before the stop-bit sampling edge, applies
   // the optional same-cycle pop / counter clear there, then checks the outcome one cycle later.
   task automatic send_frame(input logic [PW-1:0] d, input logic stop_val, input bit pop_now,
                             input bit clr_now, input int low_bits);
      drive_bit(1'b0);
      for (int i = 0; i < PW; i++) drive_bit(d[i]);
      drive_bit(stop_val);
      check_eq("pre_push_count", fifo_count, exp_q.size());
      if (pop_now) begin
         check_eq("head_at_pop", {packet_parity_err, packet_data}, exp_q[0]);
         packet_ready = 1'b1;
      end
      if (clr_now) clear_counters = 1'b1;
      @(negedge clk);
      packet_ready   = 1'b0;
      clear_counters = 1'b0;
      if (pop_now) void'(exp_q.pop_front());
      if (stop_val) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(entry_of(d));
         else if (ovf_model < CMAX) ovf_model++;
      end else if (fe_model < CMAX) begin
         fe_model++;
      end
      if (clr_now) begin
         fe_model  = 0;
         ovf_model = 0;
      end
      check_state("frame");
      if (!stop_val) begin
         repeat (low_bits * CPB) @(negedge clk);
         piso_in = 1'b1;
      end
      repeat ($urandom_range(3, 12)) @(negedge clk);
   endtask

   task automatic drain_all();
      packet_ready = 1'b1;
      while (exp_q.size() > 0) begin
         check_eq("drain_valid", packet_valid, 1'b1);
         check_eq("drain_entry", {packet_parity_err, packet_data}, exp_q[0]);
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      packet_ready = 1'b0;
      check_state("drained");
   endtask

   task automatic glitch();
      piso_in = 1'b0;
      @(negedge clk);
      piso_in = 1'b1;
      repeat (12) @(negedge clk);
      check_state("glitch");
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_data"}, packet_data, '0);
      check_eq({tag, "_perr"}, packet_parity_err, 1'b0);
      check_eq({tag, "_valid"}, packet_valid, 1'b0);
      check_eq({tag, "_count"}, fifo_count, '0);
      check_eq({tag, "_fe"}, framing_err_count, '0);
      check_eq({tag, "_ovf"}, overflow_count, '0);
   endtask

   task automatic abort_with_reset(input logic [PW-1:0] d, input int abort_bit);
      drive_bit(1'b0);
      for (int i = 0; i < abort_bit; i++) drive_bit(d[i]);
      piso_in = d[abort_bit];
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      piso_in = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      fe_model  = 0;
      ovf_model = 0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      piso_in        = 1'b1;
      packet_ready   = 1'b0;
      clear_counters = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Single good frames, even and odd parity.
      send_frame(64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 0);
      check_eq("t1_data", packet_data, 64'h8000_0000_0000_0001);
      check_eq("t1_perr", packet_parity_err, 1'b1);
      drain_all();
      send_frame(64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 0);
      check_eq("t1b_perr", packet_parity_err, 1'b0);
      drain_all();

      // Framing error with the line held low for 20 bits counts once.
      send_frame(rand_data(), 1'b0, 1'b0, 1'b0, 20);
      check_eq("t2_fe", framing_err_count, 1);
      send_frame(rand_data(), 1'b1, 1'b0, 1'b0, 0);
      drain_all();

      // Overflow with no consumer.
      for (int i = 0; i < 18; i++) send_frame(rand_data(), 1'b1, 1'b0, 1'b0, 0);
      check_eq("t3_count", fifo_count, 16);
      check_eq("t3_ovf", overflow_count, 2);

      // Full FIFO, pop in the push cycle: no drop, new packet goes last.
      send_frame(rand_data(), 1'b1, 1'b1, 1'b0, 0);
      check_eq("t4_count", fifo_count, 16);
      check_eq("t4_ovf", overflow_count, 2);
      drain_all();

      // Glitch, then reset in the middle of data bit 30.
      glitch();
      abort_with_reset(rand_data(), 30);
      send_frame(rand_data(), 1'b1, 1'b0, 1'b0, 0);
      drain_all();

      // Saturation, then clear coinciding with an increment.
      for (int i = 0; i < 17; i++) send_frame(rand_data(), 1'b0, 1'b0, 1'b0, $urandom_range(0, 2));
      check_eq("t6_sat", framing_err_count, 15);
      send_frame(rand_data(), 1'b0, 1'b0, 1'b1, 1);
      check_eq("t6_clr", framing_err_count, 0);

      // Random mix of traffic.
      for (int i = 0; i < 25; i++) begin
         int kind = int'($urandom_range(0, 9));
         if (kind < 7)      send_frame(rand_data(), 1'b1, 1'b0, 1'b0, 0);
         else if (kind < 9) send_frame(rand_data(), 1'b0, 1'b0, 1'b0, $urandom_range(0, 3));
         else               glitch();
         if ($urandom_range(0, 3) == 0) drain_all();
      end
      drain_all();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
